// File: rtl/load_store_unit.sv
// Load/store unit: RV32I byte/half/word access onto a word-wide data memory.
// LSU_MISALIGN_TRAP_EN makes misaligned H/W an error instead of force-aligning.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCESS = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] RMW_WR = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;

    logic              req_err;
    logic              illegal;
    logic [ADDR_W-1:0] addr_al;
    logic [DATA_W-1:0] shifted;
    logic [15:0]       half;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err  = illegal || misalign;
`else
    assign req_err  = illegal;
`endif

    // Halfword/word addresses are aligned at capture; in trap builds the
    // misaligned cases never reach memory so this is harmless there.
    always_comb begin
        addr_al = req_addr;
        if (req_funct3[1:0] == 2'b01)
            addr_al[0] = 1'b0;
        else if (req_funct3[1:0] == 2'b10)
            addr_al[1:0] = 2'b00;
    end

    assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    assign half    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b001:  load_ext = {{16{half[15]}}, half};
            3'b101:  load_ext = {16'd0, half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = word_q;
        if (!f3_q[0]) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    assign req_ready = (state == IDLE);
    assign mem_read  = ((state == ACCESS) && !we_q) || (state == RMW_RD);
    assign mem_write = ((state == ACCESS) && we_q) || (state == RMW_WR);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        mem_wdata = '0;
        if ((state == ACCESS) && we_q)
            mem_wdata = wdata_q;
        else if (state == RMW_WR)
            mem_wdata = merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= addr_al;
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && (req_funct3[1:0] != 2'b10)) begin
                            state <= RMW_RD;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    if (!we_q)
                        resp_rdata <= load_ext;
                end
                RMW_RD: begin
                    word_q <= mem_rdata;
                    state  <= RMW_WR;
                end
                RMW_WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-load case.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0, both_cnt = 0;
    logic [31:0] last_raddr = '0, last_waddr = '0, last_wdata = '0;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[7:2]] <= mem_wdata;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
    end

    always @(posedge clk) begin
        if (mem_read) begin
            rd_cnt     <= rd_cnt + 1;
            last_raddr <= mem_addr;
        end
        if (mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (mem_read && mem_write)
            both_cnt <= both_cnt + 1;
        if (resp_valid)
            rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = a[7:2];
        pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic err);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0BAD_0BAD;
        req_addr  = 32'hFFFF_FFFC;
        lat = 0;
        rd  = '0;
        err = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat == 0)
            check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;
    int          r0, w0, s0;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mrw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // SW then LW
        w0 = wr_cnt;
        r0 = rd_cnt;
        do_req("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, rd, err);
        check("sw_lat", lat, 2);
        check("sw_err", {31'd0, err}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        #2;
        check("sw_wrs", wr_cnt - w0, 1);
        check("sw_rds", rd_cnt - r0, 0);
        check("sw_waddr", last_waddr, 32'h10);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        check("sw_pulse", {31'd0, resp_valid}, 32'd0);
        check("sw_rdata0", resp_rdata, 32'd0);
        do_req("lw", 1'b0, 3'b010, 32'h10, 32'h0, lat, rd, err);
        check("lw_lat", lat, 2);
        check("lw_rdata", rd, 32'hDEAD_BEEF);
        check("lw_err", {31'd0, err}, 32'd0);

        // SB read-modify-write
        preload(32'h20, 32'h1122_3344);
        w0 = wr_cnt;
        r0 = rd_cnt;
        do_req("sb", 1'b1, 3'b000, 32'h21, 32'h0000_00AA, lat, rd, err);
        check("sb_lat", lat, 3);
        #2;
        check("sb_rds", rd_cnt - r0, 1);
        check("sb_wrs", wr_cnt - w0, 1);
        check("sb_wdata", last_wdata, 32'h1122_AA44);
        check("sb_mem", mem[8], 32'h1122_AA44);

        // load extension
        preload(32'h30, 32'h0000_F080);
        do_req("lb", 1'b0, 3'b000, 32'h30, 32'h0, lat, rd, err);
        check("lb", rd, 32'hFFFF_FF80);
        do_req("lbu", 1'b0, 3'b100, 32'h30, 32'h0, lat, rd, err);
        check("lbu", rd, 32'h0000_0080);
        do_req("lh", 1'b0, 3'b001, 32'h30, 32'h0, lat, rd, err);
        check("lh", rd, 32'hFFFF_F080);
        do_req("lhu", 1'b0, 3'b101, 32'h32, 32'h0, lat, rd, err);
        check("lhu", rd, 32'h0000_0000);
        do_req("lb1", 1'b0, 3'b000, 32'h31, 32'h0, lat, rd, err);
        check("lb1", rd, 32'hFFFF_FFF0);

        // illegal store size
        preload(32'h40, 32'h1234_5678);
        w0 = wr_cnt;
        r0 = rd_cnt;
        do_req("bad", 1'b1, 3'b100, 32'h40, 32'hFFFF_FFFF, lat, rd, err);
        check("bad_lat", lat, 1);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_rdata", rd, 32'd0);
        #2;
        check("bad_acc", (rd_cnt - r0) + (wr_cnt - w0), 0);
        check("bad_mem", mem[16], 32'h1234_5678);
        do_req("f3_111", 1'b0, 3'b111, 32'h40, 32'h0, lat, rd, err);
        check("f3_111_err", {31'd0, err}, 32'd1);

        // misaligned LW
        preload(32'h10, 32'hCAFE_BABE);
        r0 = rd_cnt;
        do_req("mis", 1'b0, 3'b010, 32'h13, 32'h0, lat, rd, err);
        #2;
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_err", {31'd0, err}, 32'd1);
        check("mis_lat", lat, 1);
        check("mis_rdata", rd, 32'd0);
        check("mis_rds", rd_cnt - r0, 0);
`else
        check("mis_err", {31'd0, err}, 32'd0);
        check("mis_rdata", rd, 32'hCAFE_BABE);
        check("mis_raddr", last_raddr, 32'h10);
`endif

        // reset during RMW_RD
        preload(32'h50, 32'hFFFF_FFFF);
        w0 = wr_cnt;
        s0 = rsp_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h50;
        req_wdata  = 32'h0000_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rr_busy", {30'd0, req_ready, mem_read}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rr_mread", {30'd0, mem_read, mem_write}, 32'd0);
        check("rr_ready", {31'd0, req_ready}, 32'd1);
        check("rr_maddr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rr_rsp", rsp_cnt - s0, 0);
        check("rr_wrs", wr_cnt - w0, 0);
        check("rr_mem", mem[20], 32'hFFFF_FFFF);
        check("rr_ready2", {31'd0, req_ready}, 32'd1);
        check("rw_excl", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side counterpart to the word-wide data memory.
- Accepts core load/store requests with RV32I funct3 size codes.
- Drives the memory's MemRead/MemWrite/addr/writeData interface and sign/zero-extends load data.
- Implements SB/SH as read-modify-write on the 32-bit word memory.
- Sits between the execute stage and the data memory; one request outstanding at a time.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, data width; fixed at 32, byte lanes assume 4 bytes.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  LSU idle, can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  DATA_W  store data, LSB-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors
- resp_err  output  1  request rejected, no memory access performed
- mem_read  output  1  to memory MemRead
- mem_write  output  1  to memory MemWrite
- mem_addr  output  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_wdata  output  DATA_W  to memory writeData
- mem_rdata  input  DATA_W  combinational read data from memory

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0; internal regs cleared.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. req_ready=1 only in IDLE. Request fields are registered at acceptance; later input changes are ignored.
- FSM states: IDLE, ACCESS, RMW_RD, RMW_WR, RESP.
- IDLE -> ACCESS: load, or SW.
- IDLE -> RMW_RD: SB or SH.
- IDLE -> RESP with error: illegal funct3, i.e. 011/110/111, or a store with 100/101.
- ACCESS:
  - Load: mem_read=1 for one cycle; mem_rdata is captured at the edge.
  - SW: mem_write=1 with mem_wdata=req_wdata for one cycle.
  - Then RESP.
- RMW_RD: mem_read=1; the word is captured. Then RMW_WR.
- RMW_WR: mem_write=1; mem_wdata = captured word with the addressed byte lane (addr[1:0]) or half lane (addr[1]) replaced by req_wdata[7:0] or [15:0]; other lanes unchanged. Then RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Outputs are registered; resp_rdata and resp_err are valid only while resp_valid=1 and are 0 otherwise.
- mem_read and mem_write are never both 1; both are 0 in IDLE and RESP.
- Latency, acceptance edge to resp_valid high:
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Next acceptance is possible at the edge ending RESP + 1, i.e. the first IDLE cycle.
- Load extraction: lane selected by addr[1:0] (byte) or addr[1] (half). B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes the word through.
- Reset mid-operation: an RMW in progress is abandoned. If reset asserts before the RMW_WR edge, memory is untouched. No response is produced.
- No response backpressure: the core must consume the resp_valid pulse.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is an error.
  - Goes IDLE -> RESP with resp_err=1 and resp_rdata=0, 1-cycle latency.
  - No mem_read or mem_write is asserted.
- Undefined:
  - Misaligned addresses are silently force-aligned: H clears addr[0]; W clears addr[1:0].
  - The access proceeds normally; resp_err is raised only for illegal funct3.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store resp after 2 cycles with mem_write pulse 1 cycle at mem_addr 0x10; load resp_rdata=0xDEADBEEF, resp_err=0.
- Word @0x20=0x11223344; SB 0xAA @0x21 -> exactly one mem_read cycle then one mem_write cycle with mem_wdata=0x1122AA44; resp 3 cycles after accept.
- Word @0x30=0x0000F080: LB @0x30 -> 0xFFFFFF80; LBU @0x30 -> 0x00000080; LH @0x30 -> 0xFFFFF080; LHU @0x32 -> 0x00000000.
- Store with funct3=100 @0x40 -> resp_valid 1 cycle after accept, resp_err=1, no mem_read or mem_write, memory @0x40 unchanged.
- Misaligned LW @0x13 (word @0x10=0xCAFEBABE):
  - With LSU_MISALIGN_TRAP_EN: resp_err=1, no memory access.
  - Without: resp_rdata=0xCAFEBABE, mem_addr=0x10.
- SH 0x5555 @0x50 (old word 0xFFFFFFFF), rst asserted during RMW_RD -> outputs reset immediately; no resp_valid; word @0x50 still 0xFFFFFFFF; req_ready=1 after reset release.
